// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, default sizing, and
// the initial hash value used by the compression datapath.
package sha256_pkg;

  localparam int ROUNDS_DEF    = 64;
  localparam int IDX_W_DEF     = 6;
  localparam int MSG_WORDS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // H0..H7 with H0 in the most significant word.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] iv_word(input logic [2:0] i);
    return SHA256_IV[3'd7 - i];
  endfunction

endpackage

// File: rtl/sha256_round_ctrl.sv
// Round sequencer for one SHA-256 compression: load, 64 rounds, final add,
// then a held digest-valid handshake. Supports chaining, stall and abort.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS    = ROUNDS_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int MSG_WORDS = MSG_WORDS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             blk_first,
  input  logic             stall,
  input  logic             abort,
  output logic             load_state,
  output logic             iv_sel,
  output logic             round_en,
  output logic [IDX_W-1:0] k_index,
  output logic             w_from_msg,
  output logic             final_add,
  output logic             hash_valid,
  input  logic             hash_ready,
  output logic             busy
);

  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]   MSG_LIM = (IDX_W + 1)'(MSG_WORDS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             first_q, first_d;
  logic             ren_q, ren_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      first_q <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      first_q <= first_d;
      ren_q   <= ren_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    first_d = first_q;
    if (abort) begin
      // abort beats everything; in IDLE it also blocks a pending start
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            state_d = ST_LOAD;
            first_d = blk_first;
          end
        end
        ST_LOAD: begin
          state_d = ST_ROUND;
          k_d     = '0;
        end
        ST_ROUND: begin
          if (ren_q) begin
            if (k_q == K_LAST) begin
              state_d = ST_FINAL;
              k_d     = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        ST_FINAL: state_d = ST_DONE;
        ST_DONE:  if (hash_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    // round_en is a flop so no output depends combinationally on stall;
    // stall sampled at an edge decides whether the following cycle executes.
    ren_d = (state_d == ST_ROUND) && !stall;
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign load_state  = (state_q == ST_LOAD);
  assign iv_sel      = load_state && first_q;
  assign round_en    = ren_q;
  assign k_index     = k_q;
  assign w_from_msg  = ren_q && ({1'b0, k_q} < MSG_LIM);
  assign final_add   = (state_q == ST_FINAL);
  assign hash_valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Randomized and directed bench for sha256_round_ctrl against a phase-walking
// reference that counts completed rounds from the stall/ready/abort stimulus.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;
  localparam int MSGW   = 16;
  localparam int MAXC   = 256;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic             blk_first = 1'b0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic             load_state, iv_sel, round_en, w_from_msg, final_add;
  logic             hash_valid, busy;
  logic [IDX_W-1:0] k_index;
  logic             hash_ready = 1'b1;

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W), .MSG_WORDS(MSGW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .blk_first(blk_first), .stall(stall), .abort(abort),
    .load_state(load_state), .iv_sel(iv_sel), .round_en(round_en),
    .k_index(k_index), .w_from_msg(w_from_msg), .final_add(final_add),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // per-cycle vector: {load,iv,ren,k[5:0],wmsg,fin,hv,sr,busy}
  logic [13:0] obs_v [0:MAXC-1];
  logic [13:0] exp_v [0:MAXC-1];
  logic        obs_sr0;
  bit          stim_stall [0:MAXC-1];
  bit          stim_abort [0:MAXC-1];
  bit          stim_ready [0:MAXC-1];

  function automatic void clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      stim_stall[c] = 1'b0;
      stim_abort[c] = 1'b0;
      stim_ready[c] = 1'b1;
    end
  endfunction

  // Reference: walk the block's phases, counting rounds actually executed.
  // A cycle in the round phase executes unless stall was high the cycle before.
  function automatic void build_exp(input bit first, input int n);
    int ph, t, k;
    bit ld, iv, ren, fin, hv;
    ph = stim_abort[0] ? 0 : 1;
    t  = 0;
    for (int c = 1; c <= n; c++) begin
      ld = 0; iv = 0; ren = 0; fin = 0; hv = 0; k = 0;
      case (ph)
        1: begin ld = 1; iv = first; end
        2: begin k = t; ren = !stim_stall[c-1]; end
        3: fin = 1;
        4: hv = 1;
        default: ;
      endcase
      exp_v[c] = {ld, iv, ren, 6'(k), (ren && k < MSGW), fin, hv, (ph == 0), (ph != 0)};
      if (stim_abort[c]) ph = 0;
      else case (ph)
        1: ph = 2;
        2: if (ren) begin t++; if (t == ROUNDS) ph = 3; end
        3: ph = 4;
        4: if (stim_ready[c]) ph = 0;
        default: ;
      endcase
    end
  endfunction

  task automatic run_block(input bit first, input int n);
    @(negedge clk);
    obs_sr0     = start_ready;
    start_valid = 1'b1;
    blk_first   = first;
    stall       = stim_stall[0];
    abort       = stim_abort[0];
    hash_ready  = stim_ready[0];
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start_valid = 1'b0;
      blk_first   = 1'($urandom);
      obs_v[c] = {load_state, iv_sel, round_en, k_index, w_from_msg,
                  final_add, hash_valid, start_ready, busy};
      stall      = stim_stall[c];
      abort      = stim_abort[c];
      hash_ready = stim_ready[c];
    end
  endtask

  function automatic int first_hv(input int n);
    for (int c = 1; c <= n; c++) if (obs_v[c][2]) return c;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({load_state, iv_sel, round_en, k_index, w_from_msg, final_add, hash_valid, busy} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs got %b want 0", {load_state, iv_sel, round_en, k_index, w_from_msg, final_add, hash_valid, busy});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got sr=%b busy=%b want sr=1 busy=0", start_ready, busy);
    end
  endtask

  task automatic test_single();
    int n_ren, n_w;
    clear_stim();
    build_exp(1'b1, 70);
    run_block(1'b1, 70);
    tests++;
    if (obs_sr0 !== 1'b1) begin fails++; $display("FAIL single_accept got sr=%b want 1", obs_sr0); end
    for (int c = 1; c <= 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL single c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    n_ren = 0; n_w = 0;
    for (int c = 1; c <= 70; c++) begin n_ren += int'(obs_v[c][11]); n_w += int'(obs_v[c][4]); end
    tests++;
    if (first_hv(70) != 67 || n_ren != 64 || n_w != 16) begin
      fails++;
      $display("FAIL single_summary got hv@%0d ren=%0d w=%0d want hv@67 ren=64 w=16", first_hv(70), n_ren, n_w);
    end
  endtask

  task automatic test_stall();
    int held;
    clear_stim();
    for (int c = 21; c <= 25; c++) stim_stall[c] = 1'b1;
    build_exp(1'b1, 75);
    run_block(1'b1, 75);
    for (int c = 1; c <= 75; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL stall c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    held = 0;
    for (int c = 1; c <= 75; c++) if (obs_v[c][10:5] == 6'd20 && !obs_v[c][11] && obs_v[c][0]) held++;
    tests++;
    if (first_hv(75) != 72 || held != 5) begin
      fails++;
      $display("FAIL stall_summary got hv@%0d held=%0d want hv@72 held=5", first_hv(75), held);
    end
  endtask

  task automatic test_backpressure();
    int n_hv, sr_busy;
    clear_stim();
    for (int c = 67; c <= 76; c++) stim_ready[c] = 1'b0;
    build_exp(1'b0, 80);
    run_block(1'b0, 80);
    for (int c = 1; c <= 80; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL backpressure c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    n_hv = 0; sr_busy = 0;
    for (int c = 1; c <= 77; c++) begin n_hv += int'(obs_v[c][2]); sr_busy += int'(obs_v[c][1]); end
    tests++;
    if (n_hv != 11 || sr_busy != 0 || obs_v[78][1] !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_summary got hv=%0d sr_early=%0d sr78=%b want 11 0 1", n_hv, sr_busy, obs_v[78][1]);
    end
  endtask

  task automatic test_chained();
    logic iv1;
    clear_stim();
    build_exp(1'b1, 67);
    run_block(1'b1, 67);
    iv1 = obs_v[1][12];
    for (int c = 1; c <= 67; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL chained_a c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    build_exp(1'b0, 70);
    run_block(1'b0, 70);
    tests++;
    if (obs_sr0 !== 1'b1 || iv1 !== 1'b1 || obs_v[1][13:12] !== 2'b10) begin
      fails++;
      $display("FAIL chained_iv got sr=%b iv1=%b ld/iv2=%b want 1 1 10", obs_sr0, iv1, obs_v[1][13:12]);
    end
    for (int c = 1; c <= 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL chained_b c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_abort();
    clear_stim();
    stim_abort[42] = 1'b1;
    build_exp(1'b1, 42);
    run_block(1'b1, 42);
    for (int c = 1; c <= 42; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL abort c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    clear_stim();
    build_exp(1'b1, 70);
    run_block(1'b1, 70);
    tests++;
    if (obs_sr0 !== 1'b1 || obs_v[1][13] !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart got sr=%b load=%b want 1 1", obs_sr0, obs_v[1][13]);
    end
    for (int c = 1; c <= 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL abort_restart c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    // abort alongside start in IDLE, then abort while the digest is held
    clear_stim();
    stim_abort[0] = 1'b1;
    build_exp(1'b1, 4);
    run_block(1'b1, 4);
    for (int c = 1; c <= 4; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL abort_idle c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
    clear_stim();
    for (int c = 0; c < MAXC; c++) stim_ready[c] = 1'b0;
    stim_abort[70] = 1'b1;
    build_exp(1'b0, 73);
    run_block(1'b0, 73);
    for (int c = 1; c <= 73; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL abort_done c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_random();
    bit first;
    for (int b = 0; b < 6; b++) begin
      clear_stim();
      for (int c = 0; c < 200; c++) begin
        stim_stall[c] = (c < 100) && ($urandom_range(7) == 0);
        stim_ready[c] = (c >= 100) || 1'($urandom);
        stim_abort[c] = (c >= 1) && (c < 100) && ($urandom_range(199) == 0);
      end
      stim_abort[0] = ($urandom_range(9) == 0);
      first = 1'($urandom);
      build_exp(first, 200);
      run_block(first, 200);
      for (int c = 1; c <= 200; c++) begin
        tests++;
        if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL random b=%0d c=%0d got %b want %b", b, c, obs_v[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_stim();
    run_block(1'b1, 35);
    tests++;
    if (obs_v[35][10:5] !== 6'd33 || obs_v[35][11] !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre got k=%0d ren=%b want k=33 ren=1", obs_v[35][10:5], obs_v[35][11]);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({load_state, round_en, k_index, w_from_msg, final_add, hash_valid, busy} !== 12'd0 || start_ready !== 1'b1) begin
      fails++;
      $display("FAIL areset_immediate got ren=%b k=%0d busy=%b sr=%b want 0 0 0 1", round_en, k_index, busy, start_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL areset_release got sr=%b busy=%b want 1 0", start_ready, busy);
    end
    clear_stim();
    build_exp(1'b1, 70);
    run_block(1'b1, 70);
    for (int c = 1; c <= 70; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL areset_after c=%0d got %b want %b", c, obs_v[c], exp_v[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_chained();
    test_abort();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
